// File: rtl/alu_issue_if.sv
// alu_issue_if: request/response and ALU-side bundle for alu_issue.
//   req_*   : valid/ready operation request (com, a, b, tag, fwd_a)
//   resp_*  : valid/ready result (data, tag, err)
//   alu_*   : operands to / result from the combinational ALU
//   slave modport is the alu_issue side; master is the issuer/ALU side.
// Parameter TAG_W: width of the request/response tag.
`ifndef WORD
`define WORD 31:0
`endif
`ifndef ALU_OPCODE
`define ALU_OPCODE 3:0
`endif

interface alu_issue_if #(
  parameter int TAG_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [`ALU_OPCODE] req_com;
  logic [`WORD]      req_a;
  logic [`WORD]      req_b;
  logic [TAG_W-1:0]  req_tag;
  logic              req_fwd_a;
  logic [`ALU_OPCODE] alu_com;
  logic [`WORD]      alu_in0;
  logic [`WORD]      alu_in1;
  logic [`WORD]      alu_out;
  logic              resp_valid;
  logic              resp_ready;
  logic [`WORD]      resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic              resp_err;

  modport slave (
    input  req_valid, req_com, req_a, req_b, req_tag, req_fwd_a, alu_out, resp_ready,
    output req_ready, alu_com, alu_in0, alu_in1, resp_valid, resp_data, resp_tag, resp_err
  );

  modport master (
    output req_valid, req_com, req_a, req_b, req_tag, req_fwd_a, alu_out, resp_ready,
    input  req_ready, alu_com, alu_in0, alu_in1, resp_valid, resp_data, resp_tag, resp_err
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: sequential front end for the combinational ALU.
//   Accepts one op per valid/ready request, drives the ALU from registered
//   operands, captures the result one cycle later and returns it with its tag
//   over a valid/ready response. Counts handed-off results (wrapping).
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous reset, active-high
//   io_bus      alu_issue_if.slave (req_*, resp_*, alu_*)
//   o_op_count  completed-operation counter, CNT_W bits, wraps to 0
// Optional feature: define ALU_FWD_EN to let req_fwd_a select the last result
//   as operand A.
//
// state | meaning
// IDLE  | no op in flight, ready for a request
// EXEC  | operands on alu_*, result captured at end of this cycle
// DONE  | response valid, waiting for resp_ready
`ifndef WORD
`define WORD 31:0
`endif
`ifndef ALU_OPCODE
`define ALU_OPCODE 3:0
`endif

module alu_issue #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  alu_issue_if.slave       io_bus,
  output logic [CNT_W-1:0] o_op_count
);

  localparam logic [`ALU_OPCODE] OP_THA = 'd0;
  localparam logic [`ALU_OPCODE] OP_THB = 'd1;
  localparam logic [`ALU_OPCODE] OP_ADD = 'd2;
  localparam logic [`ALU_OPCODE] OP_SUB = 'd3;
  localparam logic [`ALU_OPCODE] OP_MUL = 'd4;
  localparam logic [`ALU_OPCODE] OP_AND = 'd5;
  localparam logic [`ALU_OPCODE] OP_ORR = 'd6;
  localparam logic [`ALU_OPCODE] OP_XOR = 'd7;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [`ALU_OPCODE] r_com;
  logic [`WORD]       r_in0;
  logic [`WORD]       r_in1;
  logic [TAG_W-1:0]   r_tag;
  logic [`WORD]       r_resp_data;
  logic [TAG_W-1:0]   r_resp_tag;
  logic               r_resp_err;
  logic               r_resp_valid;
  logic [CNT_W-1:0]   r_op_count;
  logic               w_req_ready;
  logic               w_handoff;
  logic               w_accept;
  logic               w_op_ok;
  logic [`WORD]       w_op_a;
  logic [`WORD]       w_result;

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_handoff   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (io_bus.req_valid) w_state_nxt = S_EXEC;
      end
      S_EXEC: w_state_nxt = S_DONE;
      S_DONE: begin
        if (io_bus.resp_ready) begin
          w_handoff   = 1'b1;
          w_req_ready = 1'b1;
          w_state_nxt = io_bus.req_valid ? S_EXEC : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Nothing may be accepted while reset is applied.
    if (i_rst) w_req_ready = 1'b0;
  end

  assign w_accept = io_bus.req_valid & w_req_ready;

  always_comb begin
    w_op_ok = 1'b0;
    case (r_com)
      OP_THA, OP_THB, OP_ADD, OP_SUB,
      OP_MUL, OP_AND, OP_ORR, OP_XOR: w_op_ok = 1'b1;
      default:                        w_op_ok = 1'b0;
    endcase
  end

  // Unknown opcodes return zero regardless of what the ALU produces.
  assign w_result = w_op_ok ? io_bus.alu_out : '0;

`ifdef ALU_FWD_EN
  logic [`WORD] r_last;

  always_ff @(posedge i_clk) begin
    if (i_rst)                  r_last <= '0;
    else if (r_state == S_EXEC) r_last <= w_result;
  end

  // r_last is already updated when DONE accepts, so a pending result forwards.
  assign w_op_a = io_bus.req_fwd_a ? r_last : io_bus.req_a;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = io_bus.req_fwd_a;
  assign w_op_a       = io_bus.req_a;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_com        <= '0;
      r_in0        <= '0;
      r_in1        <= '0;
      r_tag        <= '0;
      r_resp_data  <= '0;
      r_resp_tag   <= '0;
      r_resp_err   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_op_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_com <= io_bus.req_com;
        r_in0 <= w_op_a;
        r_in1 <= io_bus.req_b;
        r_tag <= io_bus.req_tag;
      end
      if (r_state == S_EXEC) begin
        r_resp_data  <= w_result;
        r_resp_err   <= ~w_op_ok;
        r_resp_tag   <= r_tag;
        r_resp_valid <= 1'b1;
      end
      if (w_handoff) begin
        r_op_count   <= r_op_count + CNT_W'(1);
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign io_bus.req_ready  = w_req_ready;
  assign io_bus.alu_com    = r_com;
  assign io_bus.alu_in0    = r_in0;
  assign io_bus.alu_in1    = r_in1;
  assign io_bus.resp_valid = r_resp_valid;
  assign io_bus.resp_data  = r_resp_data;
  assign io_bus.resp_tag   = r_resp_tag;
  assign io_bus.resp_err   = r_resp_err;
  assign o_op_count        = r_op_count;

endmodule

// File: tb/tb_alu_issue.sv
`ifndef WORD
`define WORD 31:0
`endif
`ifndef ALU_OPCODE
`define ALU_OPCODE 3:0
`endif

module tb_alu_issue;
  localparam int TAG_W = 4;
  localparam int CNT_W = 4;

  localparam logic [3:0] THA = 4'd0, THB = 4'd1, ADD = 4'd2, SUB = 4'd3,
                         MUL = 4'd4, AND = 4'd5, ORR = 4'd6, XOR = 4'd7;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] op_count;
  int               checks = 0;
  int               errors = 0;
  exp_t             q[$];
  int               exp_cnt = 0;
  logic [31:0]      last_model = '0;
  bit               rand_rr = 0;

  always #5 clk = ~clk;

  alu_issue_if #(.TAG_W(TAG_W)) bus();

  alu_issue #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .io_bus(bus), .o_op_count(op_count)
  );

  // External combinational ALU; garbage on unknown opcodes.
  always_comb begin
    case (bus.alu_com)
      THA:     bus.alu_out = bus.alu_in0;
      THB:     bus.alu_out = bus.alu_in1;
      ADD:     bus.alu_out = bus.alu_in0 + bus.alu_in1;
      SUB:     bus.alu_out = bus.alu_in0 - bus.alu_in1;
      MUL:     bus.alu_out = bus.alu_in0 * bus.alu_in1;
      AND:     bus.alu_out = bus.alu_in0 & bus.alu_in1;
      ORR:     bus.alu_out = bus.alu_in0 | bus.alu_in1;
      XOR:     bus.alu_out = bus.alu_in0 ^ bus.alu_in1;
      default: bus.alu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from the operation's arithmetic meaning.
  task automatic push_exp(input logic [3:0] com, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input bit fwd, output logic [31:0] a_eff);
    longint unsigned x, y, r;
    exp_t e;
    a_eff = a;
`ifdef ALU_FWD_EN
    if (fwd) a_eff = last_model;
`endif
    x = longint'(a_eff);
    y = longint'(b);
    e.err = 1'b0;
    case (com)
      THA: r = x;
      THB: r = y;
      ADD: r = (x + y) % 64'h1_0000_0000;
      SUB: r = (x + 64'h1_0000_0000 - y) % 64'h1_0000_0000;
      MUL: r = (x * y) % 64'h1_0000_0000;
      AND: r = x & y;
      ORR: r = x | y;
      XOR: r = x ^ y;
      default: begin r = 0; e.err = 1'b1; end
    endcase
    e.data = r[31:0];
    e.tag  = tag;
    q.push_back(e);
    last_model = e.data;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [3:0] com, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input bit fwd);
    logic [31:0] a_eff;
    bit ok = 0;
    bus.req_com = com; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
    bus.req_fwd_a = fwd; bus.req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL issue_timeout: req_ready never rose for tag %0h", tag);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    push_exp(com, a, b, tag, fwd, a_eff);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a = $urandom; bus.req_b = $urandom; bus.req_com = 4'($urandom);
    chk("alu_com_hold", {60'd0, bus.alu_com}, {60'd0, com});
    chk("alu_in0_hold", {32'd0, bus.alu_in0}, {32'd0, a_eff});
    chk("alu_in1_hold", {32'd0, bus.alu_in1}, {32'd0, b});
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.resp_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding", q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic add_latency_test();
    bus.resp_ready = 1'b1;
    issue(ADD, 32'd5, 32'd7, 4'd3, 1'b0);
    @(negedge clk);
    chk("lat_exec_valid", {63'd0, bus.resp_valid}, 64'd0);
    @(negedge clk);
    chk("lat_done_valid", {63'd0, bus.resp_valid}, 64'd1);
    chk("add_data", {32'd0, bus.resp_data}, 64'd12);
    @(negedge clk);
    chk("add_op_count", {60'd0, op_count}, 64'd1);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_cnt = 0;
    end else begin
      chk("op_count", {60'd0, op_count}, 64'(exp_cnt));
      if (bus.resp_valid && bus.resp_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: data %0h tag %0h with nothing pending",
                   bus.resp_data, bus.resp_tag);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("resp_data", {32'd0, bus.resp_data}, {32'd0, e.data});
          chk("resp_tag",  {60'd0, bus.resp_tag},  {60'd0, e.tag});
          chk("resp_err",  {63'd0, bus.resp_err},  {63'd0, e.err});
        end
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rr) begin
      #1 bus.resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_com = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_tag = '0; bus.req_fwd_a = 1'b0; bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready",  {63'd0, bus.req_ready},  64'd0);
    chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("rst_resp_err",   {63'd0, bus.resp_err},   64'd0);
    chk("rst_alu_bus",    {bus.alu_in0, bus.alu_in1}, 64'd0);
    chk("rst_resp_data",  {28'd0, bus.resp_data, bus.resp_tag}, 64'd0);
    chk("rst_alu_com",    {60'd0, bus.alu_com}, 64'd0);
    chk("rst_op_count",   {60'd0, op_count}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: basic ADD with latency
    add_latency_test();

    // 2: wrap-around arithmetic
    issue(SUB, 32'd0, 32'd1, 4'd1, 1'b0);
    issue(MUL, 32'h0001_0000, 32'h0001_0000, 4'd2, 1'b0);
    drain();

    // 3: back-pressure then same-cycle accept
    bus.resp_ready = 1'b0;
    issue(XOR, 32'hF0, 32'hFF, 4'd5, 1'b0);
    bus.req_com = AND; bus.req_a = 32'h3C; bus.req_b = 32'h0F; bus.req_tag = 4'd6;
    bus.req_fwd_a = 1'b0; bus.req_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid",     {63'd0, bus.resp_valid}, 64'd1);
      chk("stall_req_ready", {63'd0, bus.req_ready},  64'd0);
      chk("stall_data",      {32'd0, bus.resp_data},  64'h0F);
      chk("stall_tag",       {60'd0, bus.resp_tag},   64'd5);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    #1;
    chk("done_req_ready", {63'd0, bus.req_ready}, 64'd1);
    begin
      logic [31:0] a_eff;
      @(posedge clk);
      push_exp(AND, 32'h3C, 32'h0F, 4'd6, 1'b0, a_eff);
      #1 bus.req_valid = 1'b0;
    end
    @(negedge clk);
    chk("valid_drop", {63'd0, bus.resp_valid}, 64'd0);
    drain();

    // 4: invalid opcode then valid op clears err
    issue(4'hC, 32'd1, 32'd2, 4'd7, 1'b0);
    issue(ORR, 32'hA0, 32'h0B, 4'd8, 1'b0);
    drain();

    // 5: reset while in EXEC
    issue(ADD, 32'd1, 32'd1, 4'd2, 1'b0);
    rst = 1'b1;
    last_model = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_valid", {63'd0, bus.resp_valid}, 64'd0);
    end
    @(posedge clk); #1;
    add_latency_test();
    drain();

    // 6: forwarding (or plain operand A without the feature)
    issue(ADD, 32'd2, 32'd3, 4'd1, 1'b0);
    issue(THA, 32'd99, 32'd0, 4'd2, 1'b1);
    drain();

    // Random traffic with random back-pressure; op_count wraps several times.
    rand_rr = 1;
    for (int n = 0; n < 60; n++) begin
      logic [3:0] com;
      com = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      issue(com, $urandom, $urandom, 4'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
    end
    rand_rr = 0;
    @(posedge clk); #2;
    bus.resp_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
